// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard hazard unit with flush sequencer, outstanding limit and stall watchdog.
// Define HAZARD_PERF_EN to add the perf_stall_cycles / perf_flush_events counters.
module hazard_scoreboard #(
   parameter int NUM_REGS        = 32,
   parameter int REG_AW          = 5,
   parameter int MAX_OUTSTANDING = 4,
   parameter int FLUSH_CYCLES    = 1,
   parameter int STALL_TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_AW-1:0]   id_rs1,
   input  logic [REG_AW-1:0]   id_rs2,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic                id_rd_we,
   input  logic                id_long_op,
   input  logic                wb_valid,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic                branch_taken,
   input  logic                ex_jump,
   output logic                stall_if,
   output logic                stall_id,
   output logic                flush_if,
   output logic                flush_id,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [3:0]          outstanding,
   output logic                hang_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]         perf_stall_cycles,
   output logic [31:0]         perf_flush_events
`endif
);
   logic [2:0] flush_cnt;
   logic [15:0] stall_cnt;
   logic [15:0] stall_next;
   logic redirect, flush_active, raw_hit, waw_hit, full_hit, stall, issue, retire;
   logic [NUM_REGS-1:0] set_mask, clr_mask;
   always_comb begin
      redirect     = ~rst & (branch_taken | ex_jump);
      flush_active = redirect | (~rst & (flush_cnt != 3'd0));
      raw_hit      = (id_rs1 != '0 && pending_mask[id_rs1]) || (id_rs2 != '0 && pending_mask[id_rs2]);
      waw_hit      = id_rd_we && id_rd != '0 && pending_mask[id_rd];
      full_hit     = id_long_op && outstanding == 4'(MAX_OUTSTANDING);
      stall        = ~rst & id_valid & ~flush_active & (raw_hit | waw_hit | full_hit);
      issue        = ~rst & id_valid & ~stall & ~flush_active & id_long_op;
      retire       = wb_valid && outstanding != 4'd0;
      clr_mask     = (wb_valid && wb_rd != '0) ? NUM_REGS'(1) << wb_rd : '0;
      set_mask     = (issue && id_rd_we && id_rd != '0) ? NUM_REGS'(1) << id_rd : '0;
      stall_next   = !stall ? 16'd0 : stall_cnt == 16'(STALL_TIMEOUT) ? stall_cnt : stall_cnt + 16'd1;
   end
   assign stall_id = stall;
   assign stall_if = stall;
   assign flush_if = flush_active;
   assign flush_id = flush_active;
   // set is OR-ed after clear so a new producer keeps ownership of its register
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_mask <= '0;
         outstanding  <= '0;
         flush_cnt    <= '0;
         stall_cnt    <= '0;
         hang_err     <= 1'b0;
      end else begin
         pending_mask <= ((pending_mask & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
         outstanding  <= outstanding + {3'b0, issue} - {3'b0, retire};
         flush_cnt    <= redirect ? 3'(FLUSH_CYCLES - 1) : flush_cnt != 3'd0 ? flush_cnt - 3'd1 : 3'd0;
         stall_cnt    <= stall_next;
         hang_err     <= hang_err | (stall_next == 16'(STALL_TIMEOUT));
      end
   end
`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_events <= '0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + {31'b0, stall};
         perf_flush_events <= perf_flush_events + {31'b0, redirect};
      end
   end
`endif
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the pipelined RV32 core. Replaces single-cycle load-use detection with a per-register scoreboard that tracks variable-latency producers (loads with memory wait states, multi-cycle M-extension ops).
- Adds a multi-cycle control-flow flush sequencer, an outstanding-op limit and a stall watchdog.
- Sits beside the ID/EX stages; drives the stall/flush controls of the IF/ID and ID/EX pipeline registers.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- REG_AW, 5, register index width; must equal clog2(NUM_REGS).
- MAX_OUTSTANDING, 4, maximum in-flight long-latency ops; range 1..15.
- FLUSH_CYCLES, 1, cycles flush_if/flush_id stay asserted after a redirect; range 1..7.
- STALL_TIMEOUT, 255, consecutive stall cycles that set hang_err; range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1  in  REG_AW  source 1 index
- id_rs2  in  REG_AW  source 2 index
- id_rd  in  REG_AW  destination index
- id_rd_we  in  1  ID instruction writes rd
- id_long_op  in  1  ID instruction is long-latency (load, mul/div)
- wb_valid  in  1  a long-latency result is written back this cycle
- wb_rd  in  REG_AW  writeback destination
- branch_taken  in  1  EX resolved taken branch
- ex_jump  in  1  EX holds JAL/JALR
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold ID, inject bubble into EX
- flush_if  out  1  squash IF/ID
- flush_id  out  1  squash ID/EX
- pending_mask  out  NUM_REGS  scoreboard state (debug)
- outstanding  out  4  in-flight long-op count
- hang_err  out  1  sticky watchdog error

Behaviour:
- Reset: all registered outputs and state clear to 0 (pending_mask, outstanding, flush counter, stall counter, hang_err). Combinational outputs evaluate to 0 in reset.
- redirect = branch_taken | ex_jump.
- flush_active = redirect | (flush_cnt != 0).
- flush_if = flush_id = flush_active.
- On redirect, flush_cnt loads FLUSH_CYCLES-1. Otherwise it decrements while nonzero.
- A redirect while flush_cnt is nonzero reloads it; no accumulation.
- raw_hit: id_rs1 != 0 and pending[id_rs1], or id_rs2 != 0 and pending[id_rs2].
- waw_hit: id_rd_we and id_rd != 0 and pending[id_rd].
- full_hit: id_long_op and outstanding == MAX_OUTSTANDING.
- stall_id = id_valid & ~flush_active & (raw_hit | waw_hit | full_hit). stall_if = stall_id.
- A flush always overrides stall in the same cycle.
- issue = id_valid & ~stall_id & ~flush_active & id_long_op.
- On issue with id_rd_we and id_rd != 0, pending[id_rd] sets at the next edge.
- On wb_valid with wb_rd != 0, pending[wb_rd] clears at the next edge.
- Set and clear of the same register in the same cycle: set wins (new producer owns the register).
- outstanding increments on issue and decrements on wb_valid; both in one cycle leaves it unchanged. A long op with id_rd_we = 0 still counts.
- wb_valid with outstanding == 0 is ignored (no underflow).
- Issue at MAX_OUTSTANDING is impossible, because full_hit stalls.
- Scoreboard is not cleared by a flush. Producers already in EX or beyond complete normally.
- Latency: a dependent instruction in ID is released the cycle after the wb_valid edge (pending clears at that edge), unless the EX stage forwards. Forwarding is outside this block.
- Watchdog: stall_cnt increments each cycle stall_id = 1 and resets to 0 when stall_id = 0. It saturates at STALL_TIMEOUT. hang_err sets when stall_cnt reaches STALL_TIMEOUT and clears only on rst.
- Reset mid-operation: all pending bits and counts drop in the same edge. Any writebacks still in flight after reset are ignored by the underflow rule.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cycles (32 bits, counts cycles with stall_id = 1) and perf_flush_events (32 bits, counts redirect cycles). Both wrap modulo 2^32 and clear on rst.
- HAZARD_PERF_EN undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: issue long op rd=5, next ID reads rs1=5. Expected: stall_id = 1 until wb_valid with wb_rd=5, release on the following cycle. rs1 = 0 never stalls.
- Outstanding limit (MAX_OUTSTANDING=4): issue 4 independent long ops, then a 5th. Expected: 5th stalls with outstanding = 4. One wb_valid → 5th issues, outstanding stays 4.
- Simultaneous events: wb_valid rd=7 in the same cycle as issue rd=7 → pending[7] = 1. Simultaneous issue and writeback → outstanding unchanged.
- Flush (FLUSH_CYCLES=3): branch_taken pulse → flush_if/flush_id high for exactly 3 cycles. A second redirect in cycle 2 extends the flush to cycle 4. A stalled ID under flush shows stall_id = 0 and sets no pending bit.
- Watchdog (STALL_TIMEOUT=10): hold a RAW hazard with no writeback → hang_err rises on the 10th stall cycle and stays high after the hazard clears until rst.
- Reset mid-op: 3 ops outstanding, rst pulse → pending_mask = 0 and outstanding = 0. A stale wb_valid afterwards leaves outstanding = 0.
